// File: rtl/qtestpd_mem_test_pkg.sv
// Shared types, widths and the fill pattern for the memory test master.
package qtestpd_mem_test_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 7;
    localparam int BE_W   = DATA_W / 8;
    localparam int NUM_W  = ADDR_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Upper half carries seed+i, lower half its complement, so no word is all-zero.
    function automatic logic [DATA_W-1:0] pattern(input logic [31:0] seed,
                                                  input logic [NUM_W-1:0] idx);
        logic [31:0] s;
        s = seed + {{(32-NUM_W){1'b0}}, idx};
        return {s, ~s};
    endfunction

endpackage

// File: rtl/qtestpd_mem_test_cmp.sv
// Expected-data pipe aligned to the slave read latency, comparator,
// saturating error counter and first-error address capture.
module qtestpd_mem_test_cmp
    import qtestpd_mem_test_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int ERR_W        = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              flush_i,
    input  logic              en_i,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic [DATA_W-1:0] readdata_i,
    output logic [ERR_W-1:0]  err_count_o,
    output logic [ADDR_W-1:0] first_err_addr_o
);

    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    logic [READ_LATENCY-1:0] vld_q;
    logic [DATA_W-1:0]       exp_q [READ_LATENCY];
    logic [ADDR_W-1:0]       adr_q [READ_LATENCY];
    logic [ERR_W-1:0]        err_q;
    logic [ADDR_W-1:0]       first_q;
    logic                    mismatch_s;

    assign mismatch_s = en_i && vld_q[READ_LATENCY-1]
                        && (readdata_i != exp_q[READ_LATENCY-1]);

    // Shift register of expected words; flushing only drops the valid bits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                exp_q[i] <= '0;
                adr_q[i] <= '0;
            end
        end else begin
            exp_q[0] <= push_data_i;
            adr_q[0] <= push_addr_i;
            for (int i = 1; i < READ_LATENCY; i++) begin
                exp_q[i] <= exp_q[i-1];
                adr_q[i] <= adr_q[i-1];
            end
            if (flush_i || clear_i) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= push_i;
                for (int i = 1; i < READ_LATENCY; i++) begin
                    vld_q[i] <= vld_q[i-1];
                end
            end
        end
    end

    // Error accounting; a compare in flight during abort still counts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q   <= '0;
            first_q <= '0;
        end else if (clear_i) begin
            err_q   <= '0;
            first_q <= '0;
        end else if (mismatch_s) begin
            if (err_q != ERR_MAX) begin
                err_q <= err_q + {{(ERR_W-1){1'b0}}, 1'b1};
            end
            if (err_q == {ERR_W{1'b0}}) begin
                first_q <= adr_q[READ_LATENCY-1];
            end
        end
    end

    assign err_count_o      = err_q;
    assign first_err_addr_o = first_q;

endmodule

// File: rtl/qtestpd_mem_test_master.sv
// Avalon-MM host that fills a word window with a seeded pattern, reads it
// back and reports mismatches; used for memory bring-up and self-test.
module qtestpd_mem_test_master
    import qtestpd_mem_test_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int ERR_W        = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [NUM_W-1:0]  num_words,
    input  logic [31:0]       seed,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W-1:0] address,
    output logic [BE_W-1:0]   byteenable,
    output logic              chipselect,
    output logic              write,
    output logic [DATA_W-1:0] writedata,
    output logic              clken,
    input  logic [DATA_W-1:0] readdata
);

    localparam int DR_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    state_e            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [NUM_W-1:0]  num_q;
    logic [31:0]       seed_q;
    logic [NUM_W-1:0]  idx_q;
    logic [DR_W-1:0]   drain_q;
    logic              busy_q;
    logic              done_q;
    logic              cs_q;
    logic              write_q;
    logic [ADDR_W-1:0] address_q;
    logic [DATA_W-1:0] writedata_q;

    logic [NUM_W-1:0]  idx_nxt_s;
    logic [ADDR_W-1:0] addr_nxt_s;
    logic              last_s;
    logic              accept_s;
    logic              abort_s;
    logic              push_s;
    logic              cmp_en_s;

    assign idx_nxt_s  = idx_q + {{(NUM_W-1){1'b0}}, 1'b1};
    assign addr_nxt_s = base_q + idx_nxt_s[ADDR_W-1:0];
    assign last_s     = (idx_q == (num_q - {{(NUM_W-1){1'b0}}, 1'b1}));
    assign accept_s   = (state_q == ST_IDLE) && start && !abort;
    assign abort_s    = (state_q != ST_IDLE) && abort;
    assign push_s     = (state_q == ST_READ);
    assign cmp_en_s   = (state_q == ST_READ) || (state_q == ST_DRAIN);

    // Sequencer: outputs are registered and describe the transfer of the current cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            num_q       <= '0;
            seed_q      <= 32'd0;
            idx_q       <= '0;
            drain_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cs_q        <= 1'b0;
            write_q     <= 1'b0;
            address_q   <= '0;
            writedata_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort_s) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                cs_q    <= 1'b0;
                write_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept_s) begin
                            base_q  <= base_addr;
                            num_q   <= num_words;
                            seed_q  <= seed;
                            idx_q   <= '0;
                            busy_q  <= 1'b1;
                            drain_q <= '0;
                            if (num_words != {NUM_W{1'b0}}) begin
                                state_q     <= ST_WRITE;
                                cs_q        <= 1'b1;
                                write_q     <= 1'b1;
                                address_q   <= base_addr;
                                writedata_q <= pattern(seed, {NUM_W{1'b0}});
                            end else begin
                                // Empty window: skip the bus and just flush out a done pulse.
                                state_q <= ST_DRAIN;
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (last_s) begin
                            state_q   <= ST_READ;
                            idx_q     <= '0;
                            write_q   <= 1'b0;
                            address_q <= base_q;
                        end else begin
                            idx_q       <= idx_nxt_s;
                            address_q   <= addr_nxt_s;
                            writedata_q <= pattern(seed_q, idx_nxt_s);
                        end
                    end
                    ST_READ: begin
                        if (last_s) begin
                            state_q <= ST_DRAIN;
                            cs_q    <= 1'b0;
                            drain_q <= '0;
                        end else begin
                            idx_q     <= idx_nxt_s;
                            address_q <= addr_nxt_s;
                        end
                    end
                    ST_DRAIN: begin
                        if (drain_q == DR_W'(READ_LATENCY - 1)) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            drain_q <= drain_q + {{(DR_W-1){1'b0}}, 1'b1};
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        cs_q    <= 1'b0;
                        write_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    qtestpd_mem_test_cmp #(
        .READ_LATENCY (READ_LATENCY),
        .ERR_W        (ERR_W)
    ) u_cmp (
        .clk_i            (clk),
        .rst_ni           (reset_n),
        .clear_i          (accept_s),
        .flush_i          (abort_s),
        .en_i             (cmp_en_s),
        .push_i           (push_s),
        .push_addr_i      (address_q),
        .push_data_i      (pattern(seed_q, idx_q)),
        .readdata_i       (readdata),
        .err_count_o      (err_count),
        .first_err_addr_o (first_err_addr)
    );

    assign busy       = busy_q;
    assign done       = done_q;
    assign chipselect = cs_q;
    assign write      = write_q;
    assign address    = address_q;
    assign writedata  = writedata_q;
    assign byteenable = {BE_W{1'b1}};
    assign clken      = 1'b1;

endmodule
